// File: rtl/acc_pkg.sv
// Shared definitions for the SHA-256 sweep accelerator: register map, CTRL/STATUS
// bit positions and the controller state encoding.
package acc_pkg;

    localparam logic [4:0] ADDR_CTRL        = 5'd16;
    localparam logic [4:0] ADDR_STATUS      = 5'd17;
    localparam logic [4:0] ADDR_NONCE_START = 5'd18;
    localparam logic [4:0] ADDR_NONCE_END   = 5'd19;
    localparam logic [4:0] ADDR_TARGET      = 5'd20;
    localparam logic [4:0] ADDR_NONCE_FOUND = 5'd21;
    localparam logic [4:0] ADDR_HASH_COUNT  = 5'd22;
    localparam logic [4:0] ADDR_HASH_BASE   = 5'd24;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_ABORT  = 2;
    localparam int CTRL_ACK    = 3;
    localparam int CTRL_IRQ_EN = 4;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_DONE      = 1;
    localparam int STAT_FOUND     = 2;
    localparam int STAT_EXHAUSTED = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/hash_clz.sv
// Leading-zero count of a 256-bit digest, counted from bit 255 downward.
// An all-zero digest yields 256.
module hash_clz (
    input  logic [255:0] digest_i,
    output logic [8:0]   count_o
);
    always_comb begin
        // NOTE: the default assignment before the loop keeps this purely combinational;
        // any path that leaves count_o unassigned would infer a latch.
        count_o = 9'd256;
        for (int i = 0; i < 256; i++) begin
            if (digest_i[i]) count_o = 9'(255 - i);
        end
    end
endmodule

// File: rtl/sha256_module.sv
// Single-block SHA-256 core: data_in[511:480] is W0, digest[255:224] is H0.
// One round per clock; done is a level that holds until the next start.
module sha256_module (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [511:0] data_in,
    output logic         done,
    output logic [255:0] digest
);
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [511:0] w_q;
    logic [255:0] st_q, digest_q, st_next, digest_sum;
    logic [5:0]   round_q;
    logic         run_q, done_q;
    logic [31:0]  a, b, c, d, e, f, g, h, t1, t2, w_new;

    always_comb begin
        {a, b, c, d, e, f, g, h} = st_q;
        t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[round_q] + w_q[511:480];
        t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        st_next = {t1 + t2, a, b, c, d + t1, e, f, g};
        // Window holds W[t..t+15]; W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t]
        w_new = (rotr(w_q[63:32], 17) ^ rotr(w_q[63:32], 19) ^ (w_q[63:32] >> 10)) + w_q[223:192]
              + (rotr(w_q[479:448], 7) ^ rotr(w_q[479:448], 18) ^ (w_q[479:448] >> 3)) + w_q[511:480];
        for (int k = 0; k < 8; k++) digest_sum[32*k +: 32] = st_next[32*k +: 32] + IV[32*k +: 32];
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // pre-edge values; blocking here would make results depend on statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q      <= '0;
            st_q     <= '0;
            digest_q <= '0;
            round_q  <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else if (start) begin
            w_q     <= data_in;
            st_q    <= IV;
            round_q <= '0;
            run_q   <= 1'b1;
            done_q  <= 1'b0;
        end else if (run_q) begin
            st_q    <= st_next;
            w_q     <= {w_q[479:0], w_new};
            round_q <= round_q + 6'd1;
            if (round_q == 6'd63) begin
                run_q    <= 1'b0;
                done_q   <= 1'b1;
                digest_q <= digest_sum;
            end
        end
    end

    assign done   = done_q;
    assign digest = digest_q;
endmodule

// File: rtl/sha256_sweep_acc.sv
// Avalon-MM SHA-256 accelerator with single-shot and nonce-sweep modes around
// sha256_module; registered read path, saturating hash counter, abort and irq.
module sha256_sweep_acc
    import acc_pkg::*;
#(
    parameter int NONCE_WORD = 3,
    parameter int TARGET_W   = 9,
    parameter int COUNT_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);
    state_t               state_q, state_d;
    logic [511:0]         msg_q, core_data;
    logic [31:0]          nonce_start_q, nonce_end_q, nonce_q, nonce_found_q, rd_data, readdata_q;
    logic [TARGET_W-1:0]  target_q;
    logic [COUNT_W-1:0]   hash_count_q;
    logic [255:0]         hash_q, core_digest;
    logic [8:0]           clz_count;
    logic mode_q, found_q, exhausted_q, irq_en_q, abort_q;
    logic busy, done_flag, core_start, core_done, core_rst;
    logic ctrl_wr, cfg_wr, cmd_abort, cmd_start, cmd_ack, clz_hit, last_nonce;

    assign ctrl_wr    = chipselect && write && (address == ADDR_CTRL);
    assign cfg_wr     = chipselect && write && !busy;
    assign cmd_abort  = ctrl_wr && writedata[CTRL_ABORT];
    assign cmd_start  = ctrl_wr && writedata[CTRL_START];
    assign cmd_ack    = ctrl_wr && writedata[CTRL_ACK];
    assign clz_hit    = 32'(clz_count) >= 32'(target_q);
    assign last_nonce = (nonce_q == nonce_end_q);
    assign core_rst   = reset || abort_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cmd_abort) state_d = ST_IDLE;
        else begin
            case (state_q)
                ST_IDLE:  if (cmd_start) state_d = ST_ISSUE;
                ST_ISSUE: state_d = ST_WAIT;
                ST_WAIT:  if (core_done) state_d = ST_CHECK;
                ST_CHECK: state_d = (!mode_q || clz_hit || last_nonce) ? ST_DONE : ST_ISSUE;
                ST_DONE:  if (cmd_ack) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy       = 1'b0;
        done_flag  = 1'b0;
        core_start = 1'b0;
        case (state_q)
            ST_ISSUE:          begin busy = 1'b1; core_start = 1'b1; end
            ST_WAIT, ST_CHECK: busy = 1'b1;
            ST_DONE:           done_flag = 1'b1;
            default:           ;
        endcase
    end

    always_comb begin
        core_data = msg_q;
        if (mode_q) core_data[32*NONCE_WORD +: 32] = nonce_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the message buffer is a register file that software reads back,
            // so it is cleared on reset like every other register here.
            msg_q         <= '0;
            nonce_start_q <= '0;
            nonce_end_q   <= '0;
            target_q      <= '0;
            nonce_q       <= '0;
            nonce_found_q <= '0;
            hash_count_q  <= '0;
            hash_q        <= '0;
            mode_q        <= 1'b0;
            found_q       <= 1'b0;
            exhausted_q   <= 1'b0;
            irq_en_q      <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            abort_q <= cmd_abort;
            if (ctrl_wr) irq_en_q <= writedata[CTRL_IRQ_EN];
            if (cfg_wr) begin
                if (address < ADDR_CTRL) msg_q[32*address[3:0] +: 32] <= writedata;
                case (address)
                    ADDR_NONCE_START: nonce_start_q <= writedata;
                    ADDR_NONCE_END:   nonce_end_q   <= writedata;
                    ADDR_TARGET:      target_q      <= writedata[TARGET_W-1:0];
                    default:          ;
                endcase
            end
            if (cmd_abort) begin
                found_q     <= 1'b0;
                exhausted_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: if (cmd_start) begin
                        mode_q       <= writedata[CTRL_MODE];
                        found_q      <= 1'b0;
                        exhausted_q  <= 1'b0;
                        hash_count_q <= '0;
                        nonce_q      <= nonce_start_q;
                    end
                    ST_WAIT: if (core_done) begin
                        hash_q <= core_digest;
                        if (hash_count_q != '1) hash_count_q <= hash_count_q + COUNT_W'(1);
                    end
                    ST_CHECK: if (mode_q) begin
                        if (clz_hit) begin
                            found_q       <= 1'b1;
                            nonce_found_q <= nonce_q;
                        end else if (last_nonce) exhausted_q <= 1'b1;
                        else nonce_q <= nonce_q + 32'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (address < ADDR_CTRL)            rd_data = msg_q[32*address[3:0] +: 32];
        else if (address >= ADDR_HASH_BASE) rd_data = hash_q[32*address[2:0] +: 32];
        else begin
            case (address)
                ADDR_STATUS:      rd_data = {28'b0, exhausted_q, found_q, done_flag, busy};
                ADDR_NONCE_START: rd_data = nonce_start_q;
                ADDR_NONCE_END:   rd_data = nonce_end_q;
                ADDR_TARGET:      rd_data = 32'(target_q);
                ADDR_NONCE_FOUND: rd_data = nonce_found_q;
                ADDR_HASH_COUNT:  rd_data = 32'(hash_count_q);
                default:          rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  readdata_q <= '0;
        else if (chipselect && read) readdata_q <= rd_data;
    end

    assign readdata = readdata_q;
    assign irq      = done_flag && irq_en_q;

    hash_clz u_clz (
        .digest_i (hash_q),
        .count_o  (clz_count)
    );

    sha256_module u_core (
        .clk     (clk),
        .rst     (core_rst),
        .start   (core_start),
        .data_in (core_data),
        .done    (core_done),
        .digest  (core_digest)
    );
endmodule

// File: tb/tb_sha256_sweep_acc.sv
// Bench for sha256_sweep_acc: register-map vector table, then hand-written
// single/sweep/abort/irq/reset sequences checked against a behavioural SHA-256 model.
module tb_sha256_sweep_acc;
    import acc_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, chipselect = 1'b0, write = 1'b0, read = 1'b0;
    logic [4:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        irq;

    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    sha256_sweep_acc dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write      (write),
        .read       (read),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // FIPS 180-4 compression of one pre-padded block; blk[511:480] is the first word.
    function automatic logic [255:0] sha256_ref(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] iv [8];
        logic [31:0] t1, t2;
        logic [255:0] res;
        iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
               32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        v = iv;
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int k = 0; k < 8; k++) res[255 - 32*k -: 32] = iv[k] + v[k];
        return res;
    endfunction

    function automatic int clz_ref(input logic [255:0] d);
        int n = 0;
        while (n < 256 && !d[255 - n]) n++;
        return n;
    endfunction

    function automatic logic [511:0] with_nonce(input logic [511:0] m, input logic [31:0] n);
        logic [511:0] r = m;
        r[32*3 +: 32] = n;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        chipselect = 1'b1; read = 1'b1; address = a;
        @(posedge clk); #1;
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic check_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, 256'(d), 256'(exp));
    endtask

    task automatic load_msg(input logic [511:0] m);
        for (int i = 0; i < 16; i++) bus_write(5'(i), m[32*i +: 32]);
    endtask

    task automatic read_hash(output logic [255:0] h);
        logic [31:0] d;
        for (int k = 0; k < 8; k++) begin
            bus_read(5'(24 + k), d);
            h[32*k +: 32] = d;
        end
    endtask

    // Polls STATUS until done; an expired budget shows up as a failed done check.
    task automatic wait_done(input string name, input int budget);
        logic [31:0] s = '0;
        for (int i = 0; i < budget && !s[STAT_DONE]; i++) bus_read(ADDR_STATUS, s);
        check({name, "_done"}, 256'(s[STAT_DONE]), 256'(1));
    endtask

    typedef struct {
        logic [4:0]  addr;
        logic        do_wr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];
    logic [511:0] abc_msg, m;
    logic [255:0] h, exp_h;
    logic [31:0]  d;
    int           hit;

    initial begin
        vecs[0] = '{ADDR_NONCE_START, 1'b1, 32'h12345678, 32'h12345678};
        vecs[1] = '{ADDR_NONCE_END,   1'b1, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[2] = '{ADDR_TARGET,      1'b1, 32'hFFFFFFFF, 32'h000001FF};
        vecs[3] = '{5'd23,            1'b1, 32'hDEADBEEF, 32'h00000000};
        vecs[4] = '{ADDR_STATUS,      1'b1, 32'hFFFFFFF0, 32'h00000000};
        vecs[5] = '{5'd5,             1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[6] = '{ADDR_NONCE_FOUND, 1'b1, 32'h00000001, 32'h00000000};
        vecs[7] = '{ADDR_HASH_COUNT,  1'b1, 32'h0000FFFF, 32'h00000000};
        vecs[8] = '{5'd15,            1'b0, 32'h00000000, 32'h00000000};
        abc_msg = {32'h61626380, 448'b0, 32'h00000018};

        repeat (3) @(posedge clk);
        #1;
        check("rst_readdata", 256'(readdata), 256'(0));
        check("rst_irq", 256'(irq), 256'(0));
        reset = 1'b0;
        check_reg("rst_status", ADDR_STATUS, 32'h0);
        read_hash(h);
        check("rst_hash", h, 256'(0));

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata);
            check_reg($sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].addr, vecs[i].exp);
        end

        // Single-shot "abc"
        load_msg(abc_msg);
        bus_write(ADDR_CTRL, 32'h1);
        wait_done("abc", 200);
        check_reg("abc_status", ADDR_STATUS, 32'h2);
        check_reg("abc_count", ADDR_HASH_COUNT, 32'h1);
        read_hash(h);
        check("abc_hash", h, 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        bus_write(ADDR_CTRL, 32'h1);
        check_reg("start_in_done_status", ADDR_STATUS, 32'h2);
        check_reg("start_in_done_count", ADDR_HASH_COUNT, 32'h1);
        bus_write(ADDR_CTRL, 32'h8);
        check_reg("ack_status", ADDR_STATUS, 32'h0);

        // Random single-shot blocks against the model
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 16; k++) m[32*k +: 32] = $urandom();
            load_msg(m);
            bus_write(ADDR_CTRL, 32'h1);
            wait_done($sformatf("rnd%0d", r), 200);
            read_hash(h);
            check($sformatf("rnd%0d_hash", r), h, sha256_ref(m));
            bus_write(ADDR_CTRL, 32'h8);
        end

        // Sweep, TARGET=0: first nonce always hits
        load_msg(abc_msg);
        bus_write(ADDR_NONCE_START, 32'h10);
        bus_write(ADDR_NONCE_END, 32'h20);
        bus_write(ADDR_TARGET, 32'h0);
        bus_write(ADDR_CTRL, 32'h3);
        wait_done("t0", 200);
        check_reg("t0_status", ADDR_STATUS, 32'h6);
        check_reg("t0_nonce", ADDR_NONCE_FOUND, 32'h10);
        check_reg("t0_count", ADDR_HASH_COUNT, 32'h1);
        read_hash(h);
        check("t0_hash", h, sha256_ref(with_nonce(abc_msg, 32'h10)));
        bus_write(ADDR_CTRL, 32'h8);

        // Sweep, TARGET=256 across the 32-bit wrap
        bus_write(ADDR_NONCE_START, 32'hFFFFFFFE);
        bus_write(ADDR_NONCE_END, 32'h1);
        bus_write(ADDR_TARGET, 32'd256);
        bus_write(ADDR_CTRL, 32'h3);
        wait_done("wrap", 600);
        check_reg("wrap_status", ADDR_STATUS, 32'hA);
        check_reg("wrap_count", ADDR_HASH_COUNT, 32'h4);
        read_hash(h);
        check("wrap_hash", h, sha256_ref(with_nonce(abc_msg, 32'h1)));
        bus_write(ADDR_CTRL, 32'h8);

        // Sweep, TARGET=8 over 0..0xFF with a random message
        for (int k = 0; k < 16; k++) m[32*k +: 32] = $urandom();
        hit = -1;
        for (int n = 0; n < 256 && hit < 0; n++)
            if (clz_ref(sha256_ref(with_nonce(m, 32'(n)))) >= 8) hit = n;
        load_msg(m);
        bus_write(ADDR_NONCE_START, 32'h0);
        bus_write(ADDR_NONCE_END, 32'hFF);
        bus_write(ADDR_TARGET, 32'd8);
        bus_write(ADDR_CTRL, 32'h3);
        wait_done("t8", 12000);
        if (hit >= 0) begin
            check_reg("t8_status", ADDR_STATUS, 32'h6);
            check_reg("t8_nonce", ADDR_NONCE_FOUND, 32'(hit));
            check_reg("t8_count", ADDR_HASH_COUNT, 32'(hit + 1));
            exp_h = sha256_ref(with_nonce(m, 32'(hit)));
        end else begin
            check_reg("t8_status", ADDR_STATUS, 32'hA);
            check_reg("t8_count", ADDR_HASH_COUNT, 32'd256);
            exp_h = sha256_ref(with_nonce(m, 32'hFF));
        end
        read_hash(h);
        check("t8_hash", h, exp_h);
        bus_write(ADDR_CTRL, 32'h8);

        // Abort wins over start in the same write
        bus_write(ADDR_CTRL, 32'h5);
        check_reg("start_abort_status", ADDR_STATUS, 32'h0);
        repeat (80) @(posedge clk);
        check_reg("start_abort_later", ADDR_STATUS, 32'h0);

        // Abort while waiting on the core, then a clean rerun
        load_msg(abc_msg);
        bus_write(ADDR_CTRL, 32'h1);
        check_reg("pre_abort_busy", ADDR_STATUS, 32'h1);
        bus_write(ADDR_CTRL, 32'h4);
        check_reg("abort_status", ADDR_STATUS, 32'h0);
        bus_write(ADDR_CTRL, 32'h1);
        wait_done("post_abort", 200);
        check_reg("post_abort_count", ADDR_HASH_COUNT, 32'h1);
        read_hash(h);
        check("post_abort_hash", h, sha256_ref(abc_msg));
        bus_write(ADDR_CTRL, 32'h8);

        // irq with MSG write attempted while busy
        for (int k = 0; k < 16; k++) m[32*k +: 32] = $urandom();
        load_msg(m);
        bus_write(ADDR_CTRL, 32'h11);
        bus_write(5'd0, ~m[31:0]);
        check("irq_busy", 256'(irq), 256'(0));
        wait_done("irq", 200);
        check("irq_done", 256'(irq), 256'(1));
        check_reg("msg_busy_write", 5'd0, m[31:0]);
        read_hash(h);
        check("irq_hash", h, sha256_ref(m));
        bus_write(ADDR_CTRL, 32'h8);
        check("irq_ack", 256'(irq), 256'(0));
        check_reg("irq_ack_status", ADDR_STATUS, 32'h0);

        // Asynchronous reset in the middle of a sweep
        bus_write(ADDR_NONCE_START, 32'h0);
        bus_write(ADDR_NONCE_END, 32'hFFFF);
        bus_write(ADDR_TARGET, 32'd256);
        bus_write(ADDR_CTRL, 32'h13);
        repeat (10) @(posedge clk);
        bus_read(ADDR_NONCE_END, d);
        check("pre_reset_read", 256'(d), 256'(32'hFFFF));
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("mid_rst_readdata", 256'(readdata), 256'(0));
        check("mid_rst_irq", 256'(irq), 256'(0));
        @(posedge clk);
        #1 reset = 1'b0;
        check_reg("mid_rst_status", ADDR_STATUS, 32'h0);
        check_reg("mid_rst_count", ADDR_HASH_COUNT, 32'h0);
        check_reg("mid_rst_msg", 5'd15, 32'h0);
        read_hash(h);
        check("mid_rst_hash", h, 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
